// File: rtl/adc_2lane_deser.sv
// Receive-side deframer for a 2-lane bitwise serial ADC link: frame search with 1-bit slip,
// lock qualification, and 16-bit word rebuild from the two data lanes.
module adc_2lane_deser #(
  parameter int         DW  = 14,
  parameter int         LCK = 4,
  parameter int         UNL = 2,
  parameter logic [7:0] FRM = 8'hF0
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          en_i,
  input  logic [1:0]    frm_i,
  input  logic [1:0]    ln1_i,
  input  logic [1:0]    ln0_i,
  output logic [DW-1:0] dat_o,
  output logic          dat_vld_o,
  output logic          lock_o,
  output logic          slip_o,
  output logic [15:0]   err_cnt_o
);

  // state    | meaning
  // SEARCH   | hunting for the frame pattern at bit offset 0 or 1, every clk
  // CHECK    | frame found, confirming LCK consecutive good frames
  // LOCKED   | emitting samples, UNL consecutive bad frames drop lock
  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [7:0] LCK_C = 8'(LCK);
  localparam logic [7:0] UNL_C = 8'(UNL);

  logic [9:0]    frm_h_q, ln1_h_q, ln0_h_q;
  logic [9:0]    frm_h_d, ln1_h_d, ln0_h_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          off_q, off_d;
  logic [7:0]    good_q, good_d;
  logic [7:0]    miss_q, miss_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          lock_q, lock_d;
  logic          slip_q, slip_d;
  logic [15:0]   err_q, err_d;

  logic          m0, m1, frm_ok;
  logic [7:0]    frm_win, l1_win, l0_win;
  logic [15:0]   word;
  logic          unused_hist;

  // Frames are tested on the history including this clk's pair, so a sample
  // is reported on the edge that captures its last bit pair.
  always_comb begin
    frm_h_d = {frm_h_q[7:0], frm_i};
    ln1_h_d = {ln1_h_q[7:0], ln1_i};
    ln0_h_d = {ln0_h_q[7:0], ln0_i};
    m0      = (frm_h_d[7:0] == FRM);
    m1      = (frm_h_d[8:1] == FRM);
    frm_win = off_q ? frm_h_d[8:1] : frm_h_d[7:0];
    l1_win  = off_q ? ln1_h_d[8:1] : ln1_h_d[7:0];
    l0_win  = off_q ? ln0_h_d[8:1] : ln0_h_d[7:0];
    frm_ok  = (frm_win == FRM);
    word    = '0;
    for (int k = 0; k < 8; k++) begin
      word[15-2*k] = l1_win[7-k];
      word[14-2*k] = l0_win[7-k];
    end
  end

  assign unused_hist = ^{frm_h_q[9:8], ln1_h_q[9:8], ln0_h_q[9:8]};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    off_d   = off_q;
    good_d  = good_q;
    miss_d  = miss_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    if (!en_i) begin
      state_d = S_SEARCH;
      good_d  = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        S_SEARCH: begin
          if (m0 || m1) begin
            off_d   = !m0;
            phase_d = 2'd0;
            good_d  = 8'd1;
            miss_d  = '0;
            state_d = (LCK_C == 8'd1) ? S_LOCKED : S_CHECK;
          end
        end
        S_CHECK: begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (frm_ok) begin
              good_d = good_q + 8'd1;
              if (good_d >= LCK_C) state_d = S_LOCKED;
            end else begin
              state_d = S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (frm_ok) begin
              vld_d  = 1'b1;
              dat_d  = word[15 -: DW];
              miss_d = '0;
            end else begin
              miss_d = miss_q + 8'd1;
              if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
              if (miss_d >= UNL_C) state_d = S_SEARCH;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
    lock_d = (state_d == S_LOCKED);
    slip_d = off_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frm_h_q <= '0;
      ln1_h_q <= '0;
      ln0_h_q <= '0;
      state_q <= S_SEARCH;
      phase_q <= '0;
      off_q   <= 1'b0;
      good_q  <= '0;
      miss_q  <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
      slip_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      frm_h_q <= frm_h_d;
      ln1_h_q <= ln1_h_d;
      ln0_h_q <= ln0_h_d;
      state_q <= state_d;
      phase_q <= phase_d;
      off_q   <= off_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
      slip_q  <= slip_d;
      err_q   <= err_d;
    end
  end

  assign dat_o     = dat_q;
  assign dat_vld_o = vld_q;
  assign lock_o    = lock_q;
  assign slip_o    = slip_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_adc_2lane_deser.sv
// Directed bench for adc_2lane_deser: builds serial frames per sample, optionally
// delayed by one bit, and checks lock, data, strobe timing, errors, enable and reset.
module tb_adc_2lane_deser;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic [1:0]  frm_i, ln1_i, ln0_i;
  logic [13:0] dat_o;
  logic        dat_vld_o, lock_o, slip_o;
  logic [15:0] err_cnt_o;

  int          n_chk = 0;
  int          n_fail = 0;
  int          vld_cnt;
  int          vld_j;
  logic [13:0] last_dat;
  bit          dly;
  int          en_drop_j;
  logic        c_f, c_1, c_0;

  adc_2lane_deser dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i),
    .frm_i(frm_i), .ln1_i(ln1_i), .ln0_i(ln0_i),
    .dat_o(dat_o), .dat_vld_o(dat_vld_o), .lock_o(lock_o),
    .slip_o(slip_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one 16-bit sample as 4 bit pairs; bad replaces the frame with all zeros.
  task automatic send_sample(input logic [15:0] w, input bit bad);
    logic [7:0] fb, v1, v0;
    fb = bad ? 8'h00 : 8'hF0;
    for (int k = 0; k < 8; k++) begin
      v1[7-k] = w[15-2*k];
      v0[7-k] = w[14-2*k];
    end
    for (int j = 0; j < 4; j++) begin
      if (dly) begin
        frm_i = (j == 0) ? {c_f, fb[7]} : {fb[8-2*j], fb[7-2*j]};
        ln1_i = (j == 0) ? {c_1, v1[7]} : {v1[8-2*j], v1[7-2*j]};
        ln0_i = (j == 0) ? {c_0, v0[7]} : {v0[8-2*j], v0[7-2*j]};
      end else begin
        frm_i = {fb[7-2*j], fb[6-2*j]};
        ln1_i = {v1[7-2*j], v1[6-2*j]};
        ln0_i = {v0[7-2*j], v0[6-2*j]};
      end
      en_i = (j == en_drop_j) ? 1'b0 : 1'b1;
      @(posedge clk_i);
      #1;
      if (dat_vld_o) begin
        vld_cnt++;
        vld_j    = j;
        last_dat = dat_o;
      end
      if (j == en_drop_j) begin
        n_chk++;
        if (lock_o !== 1'b0) begin
          n_fail++;
          $display("FAIL en_drop_lock: got %b want 0", lock_o);
        end
      end
    end
    en_i = 1'b1;
    c_f = fb[0];
    c_1 = v1[0];
    c_0 = v0[0];
  endtask

  task automatic do_reset(input bit d);
    rstn_i = 1'b0;
    dly = d;
    c_f = 1'b0; c_1 = 1'b0; c_0 = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    vld_cnt = 0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; en_i = 1'b1; frm_i = 2'b11; ln1_i = 2'b11; ln0_i = 2'b11;
    en_drop_j = -1;
    repeat (2) @(posedge clk_i);
    #1;
    n_chk++;
    if ({dat_o, dat_vld_o, lock_o, slip_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: dat=%h vld=%b lock=%b slip=%b err=%h want all 0",
               dat_o, dat_vld_o, lock_o, slip_o, err_cnt_o);
    end
  endtask

  task automatic test_aligned();
    do_reset(1'b0);
    repeat (3) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b0) begin n_fail++; $display("FAIL aligned_early_lock: got %b want 0", lock_o); end
    send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL aligned_lock: got %b want 1", lock_o); end
    n_chk++;
    if (vld_cnt != 0) begin n_fail++; $display("FAIL aligned_no_vld_while_locking: got %0d want 0", vld_cnt); end
    repeat (4) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (vld_cnt != 4) begin n_fail++; $display("FAIL aligned_vld_count: got %0d want 4", vld_cnt); end
    n_chk++;
    if (vld_j != 3) begin n_fail++; $display("FAIL aligned_vld_slot: got %0d want 3", vld_j); end
    n_chk++;
    if (last_dat !== 14'h048D) begin n_fail++; $display("FAIL aligned_data: got %h want 048d", last_dat); end
    n_chk++;
    if (slip_o !== 1'b0 || err_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL aligned_slip_err: got slip=%b err=%h want 0/0000", slip_o, err_cnt_o);
    end
  endtask

  task automatic test_slip();
    do_reset(1'b1);
    repeat (4) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b0) begin n_fail++; $display("FAIL slip_early_lock: got %b want 0", lock_o); end
    send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b1 || slip_o !== 1'b1) begin
      n_fail++; $display("FAIL slip_lock: got lock=%b slip=%b want 1/1", lock_o, slip_o);
    end
    vld_cnt = 0;
    repeat (4) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (vld_cnt != 4 || vld_j != 0) begin
      n_fail++; $display("FAIL slip_vld: got count=%0d slot=%0d want 4/0", vld_cnt, vld_j);
    end
    n_chk++;
    if (last_dat !== 14'h048D) begin n_fail++; $display("FAIL slip_data: got %h want 048d", last_dat); end
  endtask

  task automatic test_lanes();
    do_reset(1'b0);
    repeat (5) send_sample(16'hAAAA, 1'b0);
    n_chk++;
    if (last_dat !== 14'h2AAA) begin n_fail++; $display("FAIL lanes_aaaa: got %h want 2aaa", last_dat); end
    send_sample(16'h5555, 1'b0);
    n_chk++;
    if (last_dat !== 14'h1555) begin n_fail++; $display("FAIL lanes_5555: got %h want 1555", last_dat); end
  endtask

  task automatic test_errors();
    send_sample(16'h1234, 1'b0);
    vld_cnt = 0;
    send_sample(16'h1234, 1'b1);
    n_chk++;
    if (vld_cnt != 0 || err_cnt_o !== 16'd1 || lock_o !== 1'b1) begin
      n_fail++; $display("FAIL err_single: got vld=%0d err=%0d lock=%b want 0/1/1", vld_cnt, err_cnt_o, lock_o);
    end
    send_sample(16'h1234, 1'b0);
    n_chk++;
    if (vld_cnt != 1) begin n_fail++; $display("FAIL err_recover_vld: got %0d want 1", vld_cnt); end
    send_sample(16'h1234, 1'b1);
    send_sample(16'h1234, 1'b1);
    n_chk++;
    if (err_cnt_o !== 16'd3 || lock_o !== 1'b0) begin
      n_fail++; $display("FAIL err_double: got err=%0d lock=%b want 3/0", err_cnt_o, lock_o);
    end
    repeat (3) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b0) begin n_fail++; $display("FAIL err_relock_early: got %b want 0", lock_o); end
    send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b1) begin n_fail++; $display("FAIL err_relock: got %b want 1", lock_o); end
  endtask

  task automatic test_enable();
    send_sample(16'h1234, 1'b0);
    vld_cnt = 0;
    en_drop_j = 1;
    send_sample(16'h1234, 1'b0);
    en_drop_j = -1;
    n_chk++;
    if (vld_cnt != 0) begin n_fail++; $display("FAIL en_no_vld: got %0d want 0", vld_cnt); end
    repeat (2) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b0) begin n_fail++; $display("FAIL en_relock_early: got %b want 0", lock_o); end
    send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b1 || err_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL en_relock: got lock=%b err=%0d want 1/3", lock_o, err_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    send_sample(16'h1234, 1'b0);
    #3;
    rstn_i = 1'b0;
    #1;
    n_chk++;
    if ({dat_o, dat_vld_o, lock_o, slip_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: dat=%h vld=%b lock=%b slip=%b err=%h want all 0",
               dat_o, dat_vld_o, lock_o, slip_o, err_cnt_o);
    end
    do_reset(1'b0);
    repeat (5) send_sample(16'h1234, 1'b0);
    n_chk++;
    if (lock_o !== 1'b1 || vld_cnt != 1 || last_dat !== 14'h048D) begin
      n_fail++; $display("FAIL async_relock: got lock=%b vld=%0d dat=%h want 1/1/048d", lock_o, vld_cnt, last_dat);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_slip();
    test_lanes();
    test_errors();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
